// File: rtl/pipe_imem_responder.sv
// -----------------------------------------------------------------------------
// pipe_imem_responder
//   Memory end of the IF-stage fetch interface. A fetch request (byte PC) is
//   accepted in IDLE. After WAIT wait-state cycles the 32-bit instruction is
//   returned together with a one-cycle rdy pulse. A side load port writes
//   program words in any state, so memory can be filled before or during
//   fetching.
//
// Parameters
//   ADDR_W     word-address bits; depth is 2**ADDR_W words; PC[ADDR_W+1:2] index
//   WAIT       wait-state cycles between request accept and response (0..7)
//   RESET_INS  value of ins after reset and on a misaligned fetch
//
// Ports
//   clock     in   rising-edge clock
//   resetn    in   asynchronous active-low reset
//   req       in   fetch request, held with addr stable until rdy
//   addr      in   byte PC of the fetch (upper bits ignored, aliases modulo depth)
//   rdy       out  one-cycle pulse: ins/misalign valid
//   ins       out  fetched instruction (registered, holds until next response)
//   misalign  out  addr[1:0]!=0 for the answered request, valid with rdy
//   busy      out  1 while a request is in flight (state != IDLE)
//   ld_we     in   program-load write enable
//   ld_addr   in   program-load word address
//   ld_data   in   program-load data
// -----------------------------------------------------------------------------
module pipe_imem_responder #(
  parameter int          ADDR_W    = 6,
  parameter int          WAIT      = 1,
  parameter logic [31:0] RESET_INS = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic [31:0]       addr,
  output logic              rdy,
  output logic [31:0]       ins,
  output logic              misalign,
  output logic              busy,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [ADDR_W-1:0] widx_reg, widx_next;
  logic              mis_reg, mis_next;
  logic [31:0]       ins_reg;
  logic              misalign_reg;

  logic [31:0]       mem [DEPTH];

  // Decode of the live request; only meaningful while IDLE.
  logic [ADDR_W-1:0] req_idx;
  logic              req_mis;
  assign req_idx = addr[ADDR_W+1:2];
  assign req_mis = (addr[1:0] != 2'b00);

  // PC bits above the word index are deliberately ignored (address aliasing).
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  // Response load happens on the edge that enters RESP. With WAIT==0 that is
  // the accepting edge itself, so the index comes straight from addr instead
  // of the captured copy.
  logic              resp_load;
  logic [ADDR_W-1:0] load_idx;
  logic              load_mis;
  assign resp_load = (state_next == S_RESP);
  assign load_idx  = (state_reg == S_IDLE) ? req_idx : widx_reg;
  assign load_mis  = (state_reg == S_IDLE) ? req_mis : mis_reg;

  // ---------------------------------------------------------------------------
  // State register (plus datapath registers that share the reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 3'd0;
      widx_reg     <= '0;
      mis_reg      <= 1'b0;
      ins_reg      <= RESET_INS;
      misalign_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      widx_reg  <= widx_next;
      mis_reg   <= mis_next;
      if (resp_load) begin
        // Non-blocking read of mem gives read-before-write on a load collision.
        ins_reg      <= load_mis ? RESET_INS : mem[load_idx];
        misalign_reg <= load_mis;
      end
    end
  end

  // Program memory: no reset, contents survive resetn.
  always_ff @(posedge clock) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    widx_next  = widx_reg;
    mis_next   = mis_reg;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          widx_next  = req_idx;
          mis_next   = req_mis;
          cnt_next   = WAIT_CNT;
          state_next = (WAIT_CNT == 3'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_reg - 3'd1;
        // <=1 also recovers from a stray zero count instead of wrapping.
        if (cnt_reg <= 3'd1) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        // Response lasts exactly one cycle; req seen here is ignored.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    rdy      = (state_reg == S_RESP);
    busy     = (state_reg != S_IDLE);
    ins      = ins_reg;
    misalign = misalign_reg;
  end

endmodule
